// File: rtl/ram_bist_pkg.sv
// Shared types and March C- element descriptors for the RAM BIST.
package ram_bist_pkg;

  localparam int unsigned ADDR_W_DEF = 10;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic [2:0] {E0, E1, E2, E3, E4, E5} elem_t;
  typedef enum logic {RD, WR} op_t;

  // Bit e describes element e: sweep down, two ops, first op is a read,
  // read polarity (1 = ~BG), write polarity (1 = ~BG).
  localparam logic [5:0] ELEM_DOWN   = 6'b01_1000;
  localparam logic [5:0] ELEM_TWO    = 6'b01_1110;
  localparam logic [5:0] ELEM_HAS_RD = 6'b11_1110;
  localparam logic [5:0] ELEM_RD_POL = 6'b01_0100;
  localparam logic [5:0] ELEM_WR_POL = 6'b00_1010;

  function automatic logic elem_down(elem_t e);
    return ELEM_DOWN[e];
  endfunction

  function automatic logic elem_two(elem_t e);
    return ELEM_TWO[e];
  endfunction

  function automatic op_t elem_op(elem_t e, logic ph);
    return (ph || !ELEM_HAS_RD[e]) ? WR : RD;
  endfunction

  function automatic logic elem_pol(elem_t e, logic ph);
    return (elem_op(e, ph) == RD) ? ELEM_RD_POL[e] : ELEM_WR_POL[e];
  endfunction

endpackage

// File: rtl/ram_bist_addr_gen.sv
// Loadable up/down address counter; o_last flags the final address of a sweep.
module ram_bist_addr_gen
  import ram_bist_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_load_down,
  input  logic              i_step,
  input  logic              i_down,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last
);

  logic [ADDR_W-1:0] r_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr <= '0;
    end else if (i_load) begin
      r_addr <= i_load_down ? '1 : '0;
    end else if (i_step) begin
      r_addr <= i_down ? r_addr - ADDR_W'(1) : r_addr + ADDR_W'(1);
    end
  end

  assign o_addr = r_addr;
  assign o_last = i_down ? (r_addr == '0) : (r_addr == '1);

endmodule

// File: rtl/ram_bist.sv
// March C- BIST initiator for a single-port RAM with first-failure capture.
// Define RAM_BIST_ERR_CNT_EN to run to completion and count mismatches.
module ram_bist
  import ram_bist_pkg::*;
#(
  parameter int unsigned       ADDR_W = ADDR_W_DEF,
  parameter int unsigned       DATA_W = 8,
  parameter logic [DATA_W-1:0] BG     = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_pass,
  output logic [ADDR_W-1:0] o_fail_addr,
  output logic [DATA_W-1:0] o_fail_exp,
  output logic [DATA_W-1:0] o_fail_got,
  output logic [15:0]       o_err_count,
  output logic              o_ram_wr,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_wdata,
  input  logic [DATA_W-1:0] i_ram_rdata
);

  state_t            r_state;
  elem_t             r_elem;
  logic              r_phase;
  logic              r_seen;
  logic              r_busy, r_done, r_pass, r_ram_wr;
  logic [ADDR_W-1:0] r_fail_addr;
  logic [DATA_W-1:0] r_fail_exp, r_fail_got, r_ram_wdata;

  logic [ADDR_W-1:0] w_addr;
  logic              w_last, w_run, w_mismatch, w_abort;
  logic              w_op_last, w_elem_end, w_test_end;
  logic              w_load, w_load_down, w_step;
  logic [DATA_W-1:0] w_exp, w_nxt_val;
  elem_t             w_nxt_elem;
  logic              w_nxt_phase;
  op_t               w_nxt_op;

  assign w_run      = (r_state == RUN);
  assign w_exp      = elem_pol(r_elem, r_phase) ? ~BG : BG;
  assign w_mismatch = w_run && (elem_op(r_elem, r_phase) == RD) && (i_ram_rdata != w_exp);
  assign w_op_last  = !elem_two(r_elem) || r_phase;
  assign w_elem_end = w_op_last && w_last;
  assign w_test_end = w_elem_end && (r_elem == E5);
`ifdef RAM_BIST_ERR_CNT_EN
  assign w_abort = 1'b0;
`else
  assign w_abort = w_mismatch;
`endif

  always_comb begin
    w_nxt_elem  = r_elem;
    w_nxt_phase = 1'b0;
    if (!w_op_last) begin
      w_nxt_phase = 1'b1;
    end else if (w_last && (r_elem != E5)) begin
      w_nxt_elem = elem_t'(r_elem + 3'd1);
    end
  end

  assign w_nxt_op  = elem_op(w_nxt_elem, w_nxt_phase);
  assign w_nxt_val = elem_pol(w_nxt_elem, w_nxt_phase) ? ~BG : BG;

  // Outside RUN, and at the end of a test, the counter is parked at 0.
  assign w_load      = !w_run || w_elem_end || w_abort;
  assign w_load_down = w_run && !w_test_end && !w_abort && elem_down(w_nxt_elem);
  assign w_step      = w_run && w_op_last && !w_last && !w_abort;

  ram_bist_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_load),
    .i_load_down (w_load_down),
    .i_step      (w_step),
    .i_down      (elem_down(r_elem)),
    .o_addr      (w_addr),
    .o_last      (w_last)
  );

`ifdef RAM_BIST_ERR_CNT_EN
  logic [15:0] r_err_count;

  always_ff @(posedge clk) begin
    if (rst || (r_state == IDLE && i_start)) begin
      r_err_count <= '0;
    end else if (w_mismatch && (r_err_count != 16'hFFFF)) begin
      r_err_count <= r_err_count + 16'd1;
    end
  end

  assign o_err_count = r_err_count;
`else
  assign o_err_count = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_elem      <= E0;
      r_phase     <= 1'b0;
      r_seen      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_fail_addr <= '0;
      r_fail_exp  <= '0;
      r_fail_got  <= '0;
      r_ram_wr    <= 1'b0;
      r_ram_wdata <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_state     <= RUN;
            r_elem      <= E0;
            r_phase     <= 1'b0;
            r_seen      <= 1'b0;
            r_busy      <= 1'b1;
            r_pass      <= 1'b0;
            r_fail_addr <= '0;
            r_fail_exp  <= '0;
            r_fail_got  <= '0;
            r_ram_wr    <= 1'b1;
            r_ram_wdata <= BG;
          end
        end
        RUN: begin
          if (w_mismatch) begin
            r_seen <= 1'b1;
            if (!r_seen) begin
              r_fail_addr <= w_addr;
              r_fail_exp  <= w_exp;
              r_fail_got  <= i_ram_rdata;
            end
          end
          if (w_test_end || w_abort) begin
            r_state     <= DONE;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_pass      <= !(r_seen || w_mismatch);
            r_ram_wr    <= 1'b0;
            r_ram_wdata <= '0;
          end else begin
            r_elem      <= w_nxt_elem;
            r_phase     <= w_nxt_phase;
            r_ram_wr    <= (w_nxt_op == WR);
            r_ram_wdata <= (w_nxt_op == WR) ? w_nxt_val : '0;
          end
        end
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_pass      = r_pass;
  assign o_fail_addr = r_fail_addr;
  assign o_fail_exp  = r_fail_exp;
  assign o_fail_got  = r_fail_got;
  assign o_ram_wr    = r_ram_wr;
  assign o_ram_addr  = w_addr;
  assign o_ram_wdata = r_ram_wdata;

endmodule

// File: tb/tb_ram_bist.sv
// Bench for ram_bist: two DUTs (BG=00, BG=A5) on behavioural RAMs, checked
// against a March C- reference model. Honours RAM_BIST_ERR_CNT_EN.
module tb_ram_bist;

  localparam int         DEPTH      = 1024;
  localparam int         LIMIT      = 10260;
  localparam logic [9:0] FAULT_ADDR = 10'h155;

  typedef struct packed {
    logic       wr;
    logic [9:0] addr;
    logic [7:0] data;
  } op_s;

  logic       clk = 1'b0;
  logic       rst;
  logic       start     [2];
  logic       busy      [2];
  logic       done      [2];
  logic       pass      [2];
  logic [9:0] fail_addr [2];
  logic [7:0] fail_exp  [2];
  logic [7:0] fail_got  [2];
  logic [15:0] err_count [2];
  logic       ram_wr    [2];
  logic [9:0] ram_addr  [2];
  logic [7:0] ram_wdata [2];
  logic [7:0] ram_rdata [2];
  bit         fault_en  [2];
  logic [7:0] mem0 [DEPTH];
  logic [7:0] mem1 [DEPTH];

  int checks = 0;
  int failures = 0;

  op_s ref_ops[$];
  op_s obs_ops[$];
  int  ref_err;
  logic [9:0] ref_faddr;
  logic [7:0] ref_fexp, ref_fgot;

  int done_n, done_cnt, busy_cnt;
  logic obs_pass, idle_after, rst_busy, rst_wr, rst_pass;
  logic [9:0] obs_faddr;
  logic [7:0] obs_fexp, obs_fgot;
  logic [15:0] obs_err;

  always #5 clk = ~clk;

  ram_bist #(.ADDR_W(10), .DATA_W(8), .BG(8'h00)) u_dut0 (
    .clk (clk), .rst (rst), .i_start (start[0]), .o_busy (busy[0]), .o_done (done[0]),
    .o_pass (pass[0]), .o_fail_addr (fail_addr[0]), .o_fail_exp (fail_exp[0]),
    .o_fail_got (fail_got[0]), .o_err_count (err_count[0]), .o_ram_wr (ram_wr[0]),
    .o_ram_addr (ram_addr[0]), .o_ram_wdata (ram_wdata[0]), .i_ram_rdata (ram_rdata[0])
  );

  ram_bist #(.ADDR_W(10), .DATA_W(8), .BG(8'hA5)) u_dut1 (
    .clk (clk), .rst (rst), .i_start (start[1]), .o_busy (busy[1]), .o_done (done[1]),
    .o_pass (pass[1]), .o_fail_addr (fail_addr[1]), .o_fail_exp (fail_exp[1]),
    .o_fail_got (fail_got[1]), .o_err_count (err_count[1]), .o_ram_wr (ram_wr[1]),
    .o_ram_addr (ram_addr[1]), .o_ram_wdata (ram_wdata[1]), .i_ram_rdata (ram_rdata[1])
  );

  // Bit 3 of FAULT_ADDR reads back as 1 when the fault is enabled.
  assign ram_rdata[0] = mem0[ram_addr[0]] |
                        ((fault_en[0] && ram_addr[0] == FAULT_ADDR) ? 8'h08 : 8'h00);
  assign ram_rdata[1] = mem1[ram_addr[1]] |
                        ((fault_en[1] && ram_addr[1] == FAULT_ADDR) ? 8'h08 : 8'h00);

  always @(posedge clk) begin
    if (rst) for (int i = 0; i < DEPTH; i++) mem0[i] <= 8'($urandom);
    else if (ram_wr[0]) mem0[ram_addr[0]] <= ram_wdata[0];
  end

  always @(posedge clk) begin
    if (rst) for (int i = 0; i < DEPTH; i++) mem1[i] <= 8'($urandom);
    else if (ram_wr[1]) mem1[ram_addr[1]] <= ram_wdata[1];
  end

  // Reference: walk the six March C- elements over a model memory.
  task automatic build_ref(input logic [7:0] bg, input bit fault);
    logic [7:0] mm [DEPTH];
    logic [9:0] ai;
    logic [7:0] expv, got;
    bit stop;
    ref_ops.delete();
    ref_err = 0;
    ref_faddr = '0;
    ref_fexp = '0;
    ref_fgot = '0;
    stop = 0;
    for (int e = 0; e < 6 && !stop; e++) begin
      for (int k = 0; k < DEPTH && !stop; k++) begin
        ai = (e == 3 || e == 4) ? 10'(DEPTH - 1 - k) : 10'(k);
        if (e > 0) begin
          expv = (e % 2 == 0) ? ~bg : bg;
          got = mm[ai] | ((fault && ai == FAULT_ADDR) ? 8'h08 : 8'h00);
          ref_ops.push_back('{wr: 1'b0, addr: ai, data: 8'h00});
          if (got != expv) begin
            if (ref_err == 0) begin
              ref_faddr = ai;
              ref_fexp = expv;
              ref_fgot = got;
            end
            ref_err++;
`ifndef RAM_BIST_ERR_CNT_EN
            stop = 1;
`endif
          end
        end
        if (e < 5 && !stop) begin
          mm[ai] = (e % 2 == 1) ? ~bg : bg;
          ref_ops.push_back('{wr: 1'b1, addr: ai, data: mm[ai]});
        end
      end
    end
  endtask

  // Starts a test on DUT sel; n counts cycles so that n=1 is the first op cycle.
  task automatic drive_run(input int sel, input int ign_at, input int rst_at);
    int n;
    bit stop_run;
    obs_ops.delete();
    done_n = 0; done_cnt = 0; busy_cnt = 0;
    idle_after = 0; rst_busy = 1; rst_wr = 1; rst_pass = 1;
    @(negedge clk);
    start[sel] = 1'b1;
    @(posedge clk);
    #1;
    start[sel] = 1'b0;
    n = 1;
    stop_run = 0;
    while (!stop_run) begin
      if (busy[sel]) begin
        busy_cnt++;
        obs_ops.push_back('{wr: ram_wr[sel], addr: ram_addr[sel], data: ram_wdata[sel]});
      end
      if (done[sel]) begin
        done_cnt++;
        if (done_n == 0) begin
          done_n = n;
          obs_pass = pass[sel];
          obs_faddr = fail_addr[sel];
          obs_fexp = fail_exp[sel];
          obs_fgot = fail_got[sel];
          obs_err = err_count[sel];
        end
      end
      if (done_n != 0 && n == done_n + 1) begin
        idle_after = !busy[sel] && !done[sel];
        stop_run = 1;
      end
      if (rst_at != 0 && n == rst_at + 1) begin
        rst_busy = busy[sel];
        rst_wr = ram_wr[sel];
        rst_pass = pass[sel];
        rst = 1'b0;
      end
      if (rst_at != 0 && n == rst_at + 20) stop_run = 1;
      if (n >= LIMIT) stop_run = 1;
      start[sel] = (n == ign_at);
      if (rst_at != 0 && n == rst_at) rst = 1'b1;
      if (!stop_run) begin
        @(posedge clk);
        #1;
        n++;
      end
    end
    start[sel] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start[0] = 1'b0;
    start[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      checks++;
      if ({busy[s], done[s], pass[s], fail_addr[s], fail_exp[s], fail_got[s], err_count[s],
           ram_wr[s], ram_addr[s], ram_wdata[s]} !== '0) begin
        failures++;
        $display("FAIL reset_outputs dut%0d: busy=%b done=%b pass=%b wr=%b addr=%h err=%h want all 0",
                 s, busy[s], done[s], pass[s], ram_wr[s], ram_addr[s], err_count[s]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_clean_run();
    int bad_i;
    fault_en[0] = 0;
    build_ref(8'h00, 0);
    repeat ($urandom_range(1, 6)) @(posedge clk);
    drive_run(0, 100, 0);
    checks++;
    if (done_n != 10241 || done_n != ref_ops.size() + 1) begin
      failures++;
      $display("FAIL clean_done_cycle: got %0d want 10241", done_n);
    end
    checks++;
    if (busy_cnt != 10240 || done_cnt != 1) begin
      failures++;
      $display("FAIL clean_busy_len: busy=%0d done_pulses=%0d want 10240/1", busy_cnt, done_cnt);
    end
    checks++;
    if (obs_pass !== 1'b1 || obs_err !== 16'd0) begin
      failures++;
      $display("FAIL clean_result: pass=%b err=%0d want 1/0", obs_pass, obs_err);
    end
    checks++;
    if (idle_after !== 1'b1) begin
      failures++;
      $display("FAIL clean_idle_after: got %b want 1", idle_after);
    end
    bad_i = (obs_ops.size() != ref_ops.size()) ? obs_ops.size() : -1;
    for (int i = 0; i < ref_ops.size() && i < obs_ops.size() && bad_i < 0; i++)
      if (obs_ops[i].wr !== ref_ops[i].wr || obs_ops[i].addr !== ref_ops[i].addr ||
          (ref_ops[i].wr && obs_ops[i].data !== ref_ops[i].data)) bad_i = i;
    checks++;
    if (bad_i >= 0) begin
      failures++;
      $display("FAIL clean_op_seq: op %0d of %0d differs, want %0d ops", bad_i, obs_ops.size(),
               ref_ops.size());
    end
  endtask

  task automatic test_stuck_fault();
    int bad_i;
    int exp_done;
    logic [15:0] exp_err;
    fault_en[0] = 1;
    build_ref(8'h00, 1);
`ifdef RAM_BIST_ERR_CNT_EN
    exp_done = 10241;
    exp_err = 16'd3;
`else
    exp_done = 1708;
    exp_err = 16'd0;
`endif
    repeat ($urandom_range(1, 6)) @(posedge clk);
    drive_run(0, 0, 0);
    fault_en[0] = 0;
    checks++;
    if (done_n != exp_done) begin
      failures++;
      $display("FAIL fault_done_cycle: got %0d want %0d", done_n, exp_done);
    end
    checks++;
    if (obs_pass !== 1'b0 || obs_err !== exp_err) begin
      failures++;
      $display("FAIL fault_result: pass=%b err=%0d want 0/%0d", obs_pass, obs_err, exp_err);
    end
    checks++;
    if (obs_faddr !== 10'h155 || obs_fexp !== 8'h00 || obs_fgot !== 8'h08) begin
      failures++;
      $display("FAIL fault_capture: addr=%h exp=%h got=%h want 155/00/08",
               obs_faddr, obs_fexp, obs_fgot);
    end
    checks++;
    if (obs_faddr !== ref_faddr || obs_fgot !== ref_fgot || obs_fexp !== ref_fexp) begin
      failures++;
      $display("FAIL fault_capture_model: addr=%h got=%h want %h/%h", obs_faddr, obs_fgot,
               ref_faddr, ref_fgot);
    end
    bad_i = (obs_ops.size() != ref_ops.size()) ? obs_ops.size() : -1;
    for (int i = 0; i < ref_ops.size() && i < obs_ops.size() && bad_i < 0; i++)
      if (obs_ops[i].wr !== ref_ops[i].wr || obs_ops[i].addr !== ref_ops[i].addr ||
          (ref_ops[i].wr && obs_ops[i].data !== ref_ops[i].data)) bad_i = i;
    checks++;
    if (bad_i >= 0) begin
      failures++;
      $display("FAIL fault_op_seq: op %0d of %0d differs, want %0d ops", bad_i, obs_ops.size(),
               ref_ops.size());
    end
  endtask

  task automatic test_mid_reset();
    build_ref(8'h00, 0);
    drive_run(0, 0, 500);
    checks++;
    if (rst_busy !== 1'b0 || rst_wr !== 1'b0 || rst_pass !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_state: busy=%b wr=%b pass=%b want 0/0/0", rst_busy, rst_wr,
               rst_pass);
    end
    checks++;
    if (done_cnt != 0) begin
      failures++;
      $display("FAIL mid_reset_no_done: got %0d done pulses want 0", done_cnt);
    end
    drive_run(0, $urandom_range(2, 10000), 0);
    checks++;
    if (done_n != 10241 || obs_pass !== 1'b1) begin
      failures++;
      $display("FAIL after_reset_run: done=%0d pass=%b want 10241/1", done_n, obs_pass);
    end
  endtask

  task automatic test_bg_a5();
    int bad_i;
    fault_en[1] = 0;
    build_ref(8'hA5, 0);
    drive_run(1, 0, 0);
    checks++;
    if (obs_ops.size() < 1026 || obs_ops[0].data !== 8'hA5 || obs_ops[1025].data !== 8'h5A) begin
      failures++;
      $display("FAIL a5_patterns: ops=%0d first=%h e1w=%h want A5/5A", obs_ops.size(),
               (obs_ops.size() > 0) ? obs_ops[0].data : 8'h00,
               (obs_ops.size() > 1025) ? obs_ops[1025].data : 8'h00);
    end
    checks++;
    if (done_n != 10241 || obs_pass !== 1'b1) begin
      failures++;
      $display("FAIL a5_result: done=%0d pass=%b want 10241/1", done_n, obs_pass);
    end
    bad_i = (obs_ops.size() != ref_ops.size()) ? obs_ops.size() : -1;
    for (int i = 0; i < ref_ops.size() && i < obs_ops.size() && bad_i < 0; i++)
      if (obs_ops[i].wr !== ref_ops[i].wr || obs_ops[i].addr !== ref_ops[i].addr ||
          (ref_ops[i].wr && obs_ops[i].data !== ref_ops[i].data)) bad_i = i;
    checks++;
    if (bad_i >= 0) begin
      failures++;
      $display("FAIL a5_op_seq: op %0d of %0d differs, want %0d ops", bad_i, obs_ops.size(),
               ref_ops.size());
    end
  endtask

  initial begin
    fault_en[0] = 0;
    fault_en[1] = 0;
    test_reset();
    test_clean_run();
    test_stuck_fault();
    test_mid_reset();
    test_bg_a5();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_bist.md
# ram_bist

Built-in self-test initiator for the single-port byte RAM. On a `start` pulse it drives the RAM's `wr`/`addr`/`data_in` port through a March C- sequence and checks every read against the expected value on `data_out`. It reports pass/fail and captures the first failing location. It sits beside the RAM behind a mux owned by the test controller, and is the master of the RAM port while `busy` is high.

## Interface
- `ADDR_W`, default 10: RAM address width; depth = 2**ADDR_W.
- `DATA_W`, default 8: RAM data width.
- `BG`, default 8'h00: background pattern. "0" writes `BG`; "1" writes `~BG`.
- `clk  in  1`: clock.
- `rst  in  1`: reset, synchronous, active-high.
- `start  in  1`: one-cycle request, honoured only in IDLE.
- `busy  out  1`: test in progress.
- `done  out  1`: one-cycle pulse at end of test.
- `pass  out  1`: result of the last completed test; held until the next accepted start.
- `fail_addr  out  ADDR_W`: address of the first mismatch.
- `fail_exp  out  DATA_W`: expected data at the first mismatch.
- `fail_got  out  DATA_W`: read data at the first mismatch.
- `err_count  out  16`: mismatch count; saturates at 16'hFFFF.
- `ram_wr  out  1`: RAM write enable.
- `ram_addr  out  ADDR_W`: RAM address.
- `ram_wdata  out  DATA_W`: RAM write data.
- `ram_rdata  in  DATA_W`: RAM read data. Combinational from `ram_addr` when `ram_wr`=0.

## Operation
- States: IDLE, RUN, DONE.
- IDLE->RUN on `start`. RUN->DONE after the last op of element 5, or on abort. DONE->IDLE unconditionally after 1 cycle.
- Elements, in order:
  - E0: up, W0
  - E1: up, R0 W1
  - E2: up, R1 W0
  - E3: down, R0 W1
  - E4: down, R1 W0
  - E5: up, R0
- Single-op elements take 1 cycle per address. Read-write elements take 2 cycles per address: read cycle then write cycle, at the same address.
- Read cycle: `ram_wr`=0. `ram_rdata` is compared against expected (`BG` or `~BG`) and sampled at the closing clock edge.
- Write cycle: `ram_wr`=1, `ram_wdata` = target value.
- Address sweep:
  - Up elements run 0 to DEPTH-1.
  - Down elements run DEPTH-1 to 0.
  - The element advances on the last address; the address never wraps.
- On any accepted start: clear `pass`, `fail_*` and `err_count`.
- `pass`=1 at DONE iff no mismatch occurred.
- Outside RUN: `ram_wr`=0, `ram_addr`=0, `ram_wdata`=0.
- `start` during RUN or DONE is ignored.
- Reset values: all outputs 0, state IDLE.
- `rst` mid-run: IDLE on the next edge with `ram_wr`=0. No `done` pulse; `pass`=0.

## Timing
- All outputs registered.
- `start` sampled at edge T:
  - At T+1: `busy`=1 and first op presented (`ram_addr`=0, `ram_wr`=1, `ram_wdata`=`BG`).
  - Full run is 1024 + 4·2048 + 1024 = 10240 op cycles, T+1..T+10240.
  - At T+10241: `done`=1, `busy`=0, `pass` valid.
  - At T+10242: back in IDLE; `start` accepted from this cycle.
- Mismatch on the read cycle at edge E: `fail_*`/`err_count` update at E+1.

## Configuration
- `RAM_BIST_ERR_CNT_EN` defined:
  - Run to completion regardless of mismatches.
  - `err_count` increments once per mismatching read, saturating.
  - `fail_*` hold the first mismatch only.
- Undefined:
  - Abort on the first mismatch: the mismatching read is the last op. `done` occurs the cycle after that read's edge, `pass`=0.
  - `fail_*` captured.
  - `err_count` tied to 0.

## Structure
- `ram_bist_pkg` holds:
  - `state_t` {IDLE, RUN, DONE}
  - `elem_t` E0..E5
  - `op_t` {RD, WR}
  - element descriptor constants: direction, op list, read/write polarity, looked up by element index
- Sub-module `ram_bist_addr_gen`: loadable up/down address counter with `last` flag, in the package's ADDR_W.

## Test plan
- Fault-free behavioural RAM model; start at T -> `done` at T+10241, `pass`=1, `err_count`=0, `busy` high 10240 cycles.
- Model bit 3 of addr 10'h155 stuck-at-1, macro defined, BG=8'h00:
  - Required: `pass`=0, `fail_addr`=10'h155, `fail_exp`=8'h00, `fail_got`=8'h08, `err_count`=3 (E1, E3, E5 reads).
- Same fault, macro undefined:
  - `done` at T+1024+2·341+2 = T+1708; `pass`=0; `fail_*` as above.
- `start` pulsed at T+100 during RUN -> ignored; `done` still at T+10241.
- `rst` at T+500 -> next cycle `busy`=0, `ram_wr`=0, no `done`. New start then completes with `pass`=1.
- BG=8'hA5 fault-free -> E0 writes 8'hA5; first E1 write is 8'h5A; `pass`=1.
